cpu_boot_ctrl: RTL and testbench



---
 rtl/cpu_boot_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_cpu_boot_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl: boot and run controller for the 8-bit accumulator CPU.
// It takes a program image from the host as a byte stream, writes it into the
// CPU RAM through the programming port and verifies a trailing checksum byte.
// After a good load it holds the CPU in reset for RST_CYCLES cycles. It then
// runs, pauses or single-steps the CPU through a clock enable.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   i_cmd_valid/i_cmd  command strobe: 00 LOAD, 01 RUN, 10 STEP, 11 HALT
//   i_byte_valid/_in   image byte stream (2**ADDR_W data bytes, then checksum)
//   o_cpu_reset        CPU reset
//   o_cpu_prog         one-cycle RAM write pulse, with o_cpu_addr / o_cpu_data
//   o_cpu_clk_en       CPU clock enable
//   o_busy             high in LOAD, CHECK, RST_HOLD and STEP
//   o_load_ok          the last load passed its checksum
//   o_load_err         the last load failed or was aborted
//   o_state            state encoding, IDLE=0 .. STEP=6
module cpu_boot_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int RST_CYCLES  = 4,
  parameter int STEP_CYCLES = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cmd_valid,
  input  logic [1:0]        i_cmd,
  input  logic              i_byte_valid,
  input  logic [DATA_W-1:0] i_byte_in,
  output logic              o_cpu_reset,
  output logic              o_cpu_prog,
  output logic [ADDR_W-1:0] o_cpu_addr,
  output logic [DATA_W-1:0] o_cpu_data,
  output logic              o_cpu_clk_en,
  output logic              o_busy,
  output logic              o_load_ok,
  output logic              o_load_err,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_CHECK = 3'd2, S_RST_HOLD = 3'd3,
    S_PAUSE = 3'd4, S_RUN = 3'd5, S_STEP = 3'd6
  } state_t;

  localparam logic [1:0] CMD_LOAD = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_HALT = 2'b11;

  localparam int TMR_MAX = (RST_CYCLES > STEP_CYCLES) ? RST_CYCLES : STEP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0]  TMR_RST  = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_STEP = TMR_W'(STEP_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  // Count value at which the next byte is the checksum rather than data.
  localparam logic [ADDR_W:0]   IMG_LEN  = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state, w_state;
  logic [ADDR_W:0]     r_cnt, w_cnt;
  logic [DATA_W-1:0]   r_sum, w_sum;
  logic [DATA_W-1:0]   r_chk, w_chk;
  logic [TMR_W-1:0]    r_tmr, w_tmr;
  logic                r_prog, w_prog;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [DATA_W-1:0]   r_data, w_data;
  logic                r_ok, w_ok;
  logic                r_err, w_err;
  logic                r_cpu_reset, w_cpu_reset;
  logic                r_clk_en, w_clk_en;
  logic                r_busy, w_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_chk       <= '0;
      r_tmr       <= '0;
      r_prog      <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_ok        <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_clk_en    <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_sum       <= w_sum;
      r_chk       <= w_chk;
      r_tmr       <= w_tmr;
      r_prog      <= w_prog;
      r_addr      <= w_addr;
      r_data      <= w_data;
      r_ok        <= w_ok;
      r_err       <= w_err;
      r_cpu_reset <= w_cpu_reset;
      r_clk_en    <= w_clk_en;
      r_busy      <= w_busy;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_sum   = r_sum;
    w_chk   = r_chk;
    w_tmr   = r_tmr;
    w_prog  = 1'b0;
    w_addr  = r_addr;
    w_data  = r_data;
    w_ok    = r_ok;
    w_err   = r_err;

    case (r_state)
      S_LOAD: begin
        // HALT beats a simultaneous byte; any other command lets the byte in.
        if (i_cmd_valid && i_cmd == CMD_HALT) begin
          w_state = S_IDLE;
          w_err   = 1'b1;
        end else if (i_byte_valid) begin
          if (r_cnt == IMG_LEN) begin
            w_chk   = i_byte_in;
            w_state = S_CHECK;
          end else begin
            w_prog = 1'b1;
            w_addr = r_cnt[ADDR_W-1:0];
            w_data = i_byte_in;
            w_sum  = r_sum + i_byte_in;
            w_cnt  = r_cnt + CNT_ONE;
          end
        end
      end
      S_CHECK: begin
        if (r_chk == r_sum) begin
          w_ok    = 1'b1;
          w_state = S_RST_HOLD;
          w_tmr   = TMR_RST;
        end else begin
          w_err   = 1'b1;
          w_state = S_IDLE;
        end
      end
      S_RST_HOLD, S_STEP: begin
        if (r_tmr == '0) w_state = S_PAUSE;
        else             w_tmr   = r_tmr - TMR_ONE;
      end
      S_PAUSE: begin
        if (i_cmd_valid && i_cmd == CMD_RUN) begin
          w_state = S_RUN;
        end else if (i_cmd_valid && i_cmd == CMD_STEP) begin
          w_state = S_STEP;
          w_tmr   = TMR_STEP;
        end
      end
      S_RUN: begin
        if (i_cmd_valid && i_cmd == CMD_HALT) w_state = S_PAUSE;
      end
      default: ;
    endcase

    // LOAD restarts from anywhere except while a load is already in flight.
    if (i_cmd_valid && i_cmd == CMD_LOAD && r_state != S_LOAD && r_state != S_CHECK) begin
      w_state = S_LOAD;
      w_ok    = 1'b0;
      w_err   = 1'b0;
      w_cnt   = '0;
      w_sum   = '0;
    end

    // CPU controls follow the state being entered so they register in step with it.
    w_cpu_reset = !(w_state inside {S_PAUSE, S_RUN, S_STEP});
    w_clk_en    = (w_state != S_PAUSE);
    w_busy      = w_state inside {S_LOAD, S_CHECK, S_RST_HOLD, S_STEP};
  end

  assign o_state      = r_state;
  assign o_cpu_reset  = r_cpu_reset;
  assign o_cpu_prog   = r_prog;
  assign o_cpu_addr   = r_addr;
  assign o_cpu_data   = r_data;
  assign o_cpu_clk_en = r_clk_en;
  assign o_busy       = r_busy;
  assign o_load_ok    = r_ok;
  assign o_load_err   = r_err;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Self-checking bench for cpu_boot_ctrl. RAM writes are checked against a
// scoreboard queue that is filled as bytes are driven.
module tb_cpu_boot_ctrl;
  localparam int N = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       cpu_reset, cpu_prog, cpu_clk_en, busy, load_ok, load_err;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_data;
  logic [2:0] state;

  int vecs = 0;
  int errs = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_w;
  logic [7:0]  img [N];

  cpu_boot_ctrl #(.ADDR_W(4), .DATA_W(8), .RST_CYCLES(4), .STEP_CYCLES(7)) dut (
    .clk(clk), .reset(reset),
    .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_byte_valid(byte_valid), .i_byte_in(byte_in),
    .o_cpu_reset(cpu_reset), .o_cpu_prog(cpu_prog),
    .o_cpu_addr(cpu_addr), .o_cpu_data(cpu_data),
    .o_cpu_clk_en(cpu_clk_en), .o_busy(busy),
    .o_load_ok(load_ok), .o_load_err(load_err), .o_state(state)
  );

  always #5 clk = ~clk;

  // Every prog pulse must match the oldest byte still owed to the RAM.
  always @(negedge clk) begin
    if (cpu_prog === 1'b1) begin
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL prog_stray: addr=%0d data=%h, required no write", cpu_addr, cpu_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({cpu_addr, cpu_data} !== exp_w) begin
          errs++;
          $display("FAIL prog_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   cpu_addr, cpu_data, exp_w[11:8], exp_w[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    cmd_valid = 1'b0;
    byte_valid = 1'b0;
    vecs++;
    if ({state, cpu_reset, cpu_prog, cpu_addr, cpu_data, cpu_clk_en, busy, load_ok, load_err}
        !== {3'd0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL reset_vals: state=%0d rst=%b prog=%b addr=%0d data=%h en=%b busy=%b ok=%b err=%b, required 0 1 0 0 00 1 0 0 0",
               state, cpu_reset, cpu_prog, cpu_addr, cpu_data, cpu_clk_en, busy, load_ok, load_err);
    end
  endtask

  task automatic do_load_cmd;
    cmd_valid = 1'b1;
    cmd = 2'b00;
    tick;
    cmd_valid = 1'b0;
    vecs++;
    if ({state, busy, load_ok, load_err} !== {3'd1, 1'b1, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL load_enter: state=%0d busy=%b ok=%b err=%b, required 1 1 0 0",
               state, busy, load_ok, load_err);
    end
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'b1;
      byte_in = img[i];
      exp_q.push_back({4'(i), img[i]});
      tick;
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_load(input bit good);
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < N; i++) sum = sum + img[i];
    do_load_cmd;
    send_bytes(N);
    byte_valid = 1'b1;
    byte_in = good ? sum : sum + 8'h01;
    tick;
    byte_valid = 1'b0;
    vecs++;
    if ({state, cpu_reset, busy} !== {3'd2, 1'b1, 1'b1}) begin
      errs++;
      $display("FAIL check_state: state=%0d rst=%b busy=%b, required 2 1 1", state, cpu_reset, busy);
    end
    tick;
    if (good) begin
      for (int k = 0; k < 4; k++) begin
        vecs++;
        if ({state, cpu_reset, load_ok} !== {3'd3, 1'b1, 1'b1}) begin
          errs++;
          $display("FAIL rst_hold cyc%0d: state=%0d rst=%b ok=%b, required 3 1 1", k, state, cpu_reset, load_ok);
        end
        tick;
      end
      vecs++;
      if ({state, cpu_reset, cpu_clk_en, busy, load_ok, load_err} !== {3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
        errs++;
        $display("FAIL load_done: state=%0d rst=%b en=%b busy=%b ok=%b err=%b, required 4 0 0 0 1 0",
                 state, cpu_reset, cpu_clk_en, busy, load_ok, load_err);
      end
    end else begin
      vecs++;
      if ({state, cpu_reset, load_ok, load_err} !== {3'd0, 1'b1, 1'b0, 1'b1}) begin
        errs++;
        $display("FAIL bad_chk: state=%0d rst=%b ok=%b err=%b, required 0 1 0 1", state, cpu_reset, load_ok, load_err);
      end
      cmd_valid = 1'b1;
      cmd = 2'b01;
      tick;
      cmd_valid = 1'b0;
      vecs++;
      if ({state, cpu_reset, load_err} !== {3'd0, 1'b1, 1'b1}) begin
        errs++;
        $display("FAIL run_in_idle: state=%0d rst=%b err=%b, required 0 1 1", state, cpu_reset, load_err);
      end
    end
    vecs++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL prog_missing: %0d writes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_step;
    int n;
    cmd_valid = 1'b1;
    cmd = 2'b10;
    tick;
    n = 0;
    while (state === 3'd6 && n < 20) begin
      vecs++;
      if ({cpu_clk_en, cpu_reset, busy} !== {1'b1, 1'b0, 1'b1}) begin
        errs++;
        $display("FAIL step_cyc%0d: en=%b rst=%b busy=%b, required 1 0 1", n, cpu_clk_en, cpu_reset, busy);
      end
      n++;
      if (n == 3) begin
        cmd_valid = 1'b1;
        cmd = 2'b11;
      end else begin
        cmd_valid = 1'b0;
      end
      tick;
    end
    cmd_valid = 1'b0;
    vecs++;
    if (n != 7) begin
      errs++;
      $display("FAIL step_len: %0d cycles, required 7", n);
    end
    vecs++;
    if ({state, cpu_clk_en, cpu_reset} !== {3'd4, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL step_end: state=%0d en=%b rst=%b, required 4 0 0", state, cpu_clk_en, cpu_reset);
    end
  endtask

  task automatic test_run;
    cmd_valid = 1'b1;
    cmd = 2'b01;
    tick;
    for (int i = 0; i < 20; i++) begin
      vecs++;
      if ({state, cpu_clk_en, cpu_reset} !== {3'd5, 1'b1, 1'b0}) begin
        errs++;
        $display("FAIL run_cyc%0d: state=%0d en=%b rst=%b, required 5 1 0", i, state, cpu_clk_en, cpu_reset);
      end
      cmd_valid = (i == 5 || i == 19);
      cmd = (i == 19) ? 2'b11 : 2'b10;
      tick;
    end
    cmd_valid = 1'b0;
    vecs++;
    if ({state, cpu_clk_en, cpu_reset} !== {3'd4, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL run_halt: state=%0d en=%b rst=%b, required 4 0 0", state, cpu_clk_en, cpu_reset);
    end
  endtask

  task automatic test_abort;
    do_load_cmd;
    send_bytes(5);
    byte_valid = 1'b1;
    byte_in = img[5];
    cmd_valid = 1'b1;
    cmd = 2'b11;
    tick;
    byte_valid = 1'b0;
    cmd_valid = 1'b0;
    vecs++;
    if ({state, load_err, load_ok, cpu_reset} !== {3'd0, 1'b1, 1'b0, 1'b1}) begin
      errs++;
      $display("FAIL abort: state=%0d err=%b ok=%b rst=%b, required 0 1 0 1", state, load_err, load_ok, cpu_reset);
    end
    tick;
    tick;
    test_load(1'b1);
  endtask

  task automatic test_reset_mid;
    do_load_cmd;
    send_bytes(9);
    byte_valid = 1'b1;
    byte_in = img[9];
    test_reset;
    test_load(1'b1);
    cmd_valid = 1'b1;
    cmd = 2'b01;
    tick;
    cmd_valid = 1'b0;
    tick;
    tick;
    test_reset;
    test_load(1'b1);
  endtask

  initial begin
    img[0] = 8'h61;
    for (int i = 1; i < N - 1; i++) img[i] = 8'h12 + 8'(8'h11 * (i - 1));
    img[N-1] = 8'h10;
    test_reset;
    test_load(1'b1);
    test_step;
    test_run;
    test_load(1'b0);
    test_abort;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
